assert_stim_seq: RTL
====================

// Module: assert_stim_seq
// PURPOSE
// Programmable stimulus sequencer. It is the driving end of the immediate-assertion checkers
// used across the verification tree. A small table holds {vector, hold} entries. On start,
// the block plays the entries back on vec_out ({a,b,c,d}), one entry after another, with
// cycle-exact timing. The checker under test samples vec_out on the same clk.
// PARAMETERS
// DEPTH   8  number of table entries (>=2)
// VEC_W   4  stimulus width; for VEC_W=4, bit3=a, bit2=b, bit1=c, bit0=d
// HOLD_W  8  hold-count width; an entry with hold=h drives vec_out for h+1 cycles
// PORTS
// clk        in   1                    clock; all state updates on posedge
// rst_n      in   1                    asynchronous reset, active low
// load_en    in   1                    write one table entry this cycle
// load_addr  in   $clog2(DEPTH)        table index to write
// load_vec   in   VEC_W                vector to store
// load_hold  in   HOLD_W               hold count to store
// start      in   1                    begin playback (1-cycle pulse)
// num_steps  in   $clog2(DEPTH+1)      entries to play; sampled on accepted start
// loop       in   1                    wrap to entry 0 after the last entry; sampled on start
// abort      in   1                    stop playback immediately
// vec_out    out  VEC_W                registered stimulus
// step_idx   out  $clog2(DEPTH)        index of the entry currently driven
// busy       out  1                    high while in PLAY
// done       out  1                    1-cycle pulse when a non-loop playback completes
// err        out  1                    1-cycle pulse on a rejected command
// BEHAVIOUR
// - Reset (rst_n=0, async): state=IDLE. vec_out, step_idx, busy, done, err = 0.
//   Every table entry is cleared to {0,0}. Applies mid-playback too; no done pulse.
// - FSM states: IDLE, PLAY, DONE. All outputs are registered.
// - IDLE:
//   - start with 1<=num_steps<=DEPTH -> PLAY.
//     - Next cycle: vec_out=tbl[0].vec, step_idx=0, busy=1, hold_cnt=tbl[0].hold.
//     - Latency is 1 clk from start to the first vector.
//   - start with num_steps=0 or >DEPTH: stay in IDLE, err=1 for 1 cycle.
// - PLAY, each cycle:
//   - hold_cnt>0: decrement it.
//   - hold_cnt==0 and step_idx<last (last=num_steps-1): step_idx++, load the next vec/hold.
//   - hold_cnt==0 at the last entry with loop=1: step_idx=0, reload entry 0. No gap cycle.
//   - hold_cnt==0 at the last entry with loop=0: -> DONE.
//     - Next cycle: vec_out=0, busy=0, done=1.
// - DONE: lasts 1 cycle, then -> IDLE. done is high only in that cycle.
// - abort (any state except reset):
//   - Next cycle: IDLE, vec_out=0, busy=0, no done.
//   - abort and start together in IDLE: abort wins, start is ignored, no err.
// - start while busy (PLAY/DONE): ignored, err=1 for 1 cycle.
// - load_en:
//   - Writes the table only in IDLE.
//   - load_en in PLAY/DONE is dropped with err=1.
//   - load_en and start in the same IDLE cycle: the write lands first, so playback sees the
//     new entry.
// - Arithmetic: hold_cnt is HOLD_W wide and never wraps (it stops at 0).
//   step_idx wraps only through the loop rule.
// - err is the OR of all rejection causes in a cycle; there is no error accumulation.
// TESTING
// 1 Reset/basic:
//   - Stimulus: load tbl = {0000,h1},{1111,h0},{0101,h1},{1111,h0}; num_steps=4, loop=0; start at t0.
//   - Required: vec_out = 0000,0000,1111,0101,0101,1111 on cycles t0+1..t0+6; done at t0+7 with vec_out=0.
// 2 Loop:
//   - Stimulus: same table, loop=1; run 14 cycles, then abort.
//   - Required: the 6-cycle pattern repeats with no gap; vec_out=0, busy=0 the cycle after abort; done never asserts.
// 3 Errors:
//   - Stimulus: start with num_steps=0; then start during PLAY; then load_en during PLAY.
//   - Required: each gives a 1-cycle err pulse; the table and playback are unchanged.
// 4 Boundary:
//   - Stimulus (a): num_steps=1, hold=255.
//   - Required (a): vec_out held for exactly 256 cycles, then done.
//   - Stimulus (b): num_steps=DEPTH.
//   - Required (b): step_idx reaches DEPTH-1 and does not overflow.
// 5 Reset mid-playback:
//   - Stimulus: assert rst_n=0 asynchronously between clk edges during PLAY.
//   - Required: outputs go 0 immediately, no done pulse; after release, start with num_steps=1 plays a 0000 vector (table cleared).
// 6 Collision:
//   - Stimulus: start+abort in the same IDLE cycle.
//   - Required: busy stays 0, no err.
//   - Stimulus: load_en+start in the same cycle at addr 0 with vec=1010.
//   - Required: first vec_out = 1010.

Source files
------------

// File: rtl/assert_stim_seq_if.sv
// ----------------------------------------------------------------------------
// assert_stim_seq_if : table-load / playback control bundle for assert_stim_seq
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface assert_stim_seq_if #(
    parameter int DEPTH  = 8,
    parameter int VEC_W  = 4,
    parameter int HOLD_W = 8
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              load_en;
    logic [IDX_W-1:0]  load_addr;
    logic [VEC_W-1:0]  load_vec;
    logic [HOLD_W-1:0] load_hold;
    logic              start;
    logic [CNT_W-1:0]  num_steps;
    logic              loop;
    logic              abort;
    logic [VEC_W-1:0]  vec_out;
    logic [IDX_W-1:0]  step_idx;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output load_en, load_addr, load_vec, load_hold, start, num_steps, loop, abort,
        input  vec_out, step_idx, busy, done, err
    );

    modport slave (
        input  load_en, load_addr, load_vec, load_hold, start, num_steps, loop, abort,
        output vec_out, step_idx, busy, done, err
    );
endinterface

`default_nettype wire

// File: rtl/assert_stim_seq.sv
// ----------------------------------------------------------------------------
// assert_stim_seq : programmable {vector, hold} table played back cycle-exactly
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module assert_stim_seq #(
    parameter int DEPTH  = 8,
    parameter int VEC_W  = 4,
    parameter int HOLD_W = 8
) (
    input wire logic          clk,
    input wire logic          rst_n,
    assert_stim_seq_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [VEC_W-1:0]  tbl_vec  [DEPTH];
    logic [HOLD_W-1:0] tbl_hold [DEPTH];
    logic [HOLD_W-1:0] hold_cnt;
    logic [IDX_W-1:0]  last_idx;
    logic              loop_lat;
    logic [VEC_W-1:0]  vec;
    logic [IDX_W-1:0]  step_idx;
    logic              busy;
    logic              done;
    logic              err;

    logic              start_ok;
    logic              bypass0;
    logic [VEC_W-1:0]  first_vec;
    logic [HOLD_W-1:0] first_hold;
    logic [IDX_W-1:0]  nxt_idx;
    logic              reject;

    assign start_ok   = (bus.num_steps != '0) && (bus.num_steps <= DEPTH_CNT);
    // A same-cycle write to entry 0 must be visible to the playback it starts.
    assign bypass0    = bus.load_en && (bus.load_addr == '0);
    assign first_vec  = bypass0 ? bus.load_vec  : tbl_vec[0];
    assign first_hold = bypass0 ? bus.load_hold : tbl_hold[0];
    assign nxt_idx    = step_idx + IDX_W'(1);

    always_comb begin
        reject = 1'b0;
        if (state != IDLE) begin
            reject = bus.start || bus.load_en;
        end else if (bus.start && !bus.abort && !start_ok) begin
            reject = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            hold_cnt <= '0;
            last_idx <= '0;
            loop_lat <= 1'b0;
            vec      <= '0;
            step_idx <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                tbl_vec[i]  <= '0;
                tbl_hold[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            err  <= reject;
            if (state == IDLE && bus.load_en) begin
                tbl_vec[bus.load_addr]  <= bus.load_vec;
                tbl_hold[bus.load_addr] <= bus.load_hold;
            end
            if (bus.abort) begin
                state    <= IDLE;
                hold_cnt <= '0;
                vec      <= '0;
                step_idx <= '0;
                busy     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start && start_ok) begin
                            state    <= PLAY;
                            vec      <= first_vec;
                            hold_cnt <= first_hold;
                            step_idx <= '0;
                            busy     <= 1'b1;
                            last_idx <= IDX_W'(bus.num_steps - CNT_W'(1));
                            loop_lat <= bus.loop;
                        end
                    end
                    PLAY: begin
                        if (hold_cnt != '0) begin
                            hold_cnt <= hold_cnt - HOLD_W'(1);
                        end else if (step_idx < last_idx) begin
                            step_idx <= nxt_idx;
                            vec      <= tbl_vec[nxt_idx];
                            hold_cnt <= tbl_hold[nxt_idx];
                        end else if (loop_lat) begin
                            step_idx <= '0;
                            vec      <= tbl_vec[0];
                            hold_cnt <= tbl_hold[0];
                        end else begin
                            state    <= DONE;
                            vec      <= '0;
                            step_idx <= '0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                        vec   <= '0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.vec_out  = vec;
    assign bus.step_idx = step_idx;
    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.err      = err;

endmodule

`default_nettype wire
